// File: rtl/mul_sequencer_if.sv
// EX-stage multiplier handshake bundle.
// Start/flush/operands in; stall, done and product out.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic             SignedE;
  logic             FlushE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             StallReqE;
  logic             DoneE;
  logic [WIDTH-1:0] ResultLoE;
  logic [WIDTH-1:0] ResultHiE;

  modport master (
    output StartE, SignedE, FlushE,
    output SrcAE, SrcBE,
    input  StallReqE, DoneE,
    input  ResultLoE, ResultHiE
  );

  modport slave (
    input  StartE, SignedE, FlushE,
    input  SrcAE, SrcBE,
    output StallReqE, DoneE,
    output ResultLoE, ResultHiE
  );
endinterface

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for EX (MUL/UMULL/SMULL).
// One product bit per cycle; stalls the pipe until done.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mul_sequencer_if.slave  s
);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   res_q, res_d;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic            stall;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1).
  always_comb begin
    a_abs = s.SrcAE;
    b_abs = s.SrcBE;
    if (s.SignedE && s.SrcAE[WIDTH-1]) a_abs = -s.SrcAE;
    if (s.SignedE && s.SrcBE[WIDTH-1]) b_abs = -s.SrcBE;
  end

  // Next-state, datapath step and stall request.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    res_d    = res_q;
    stall    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s.StartE && !s.FlushE) begin
          stall    = 1'b1;
          mcand_d  = {{WIDTH{1'b0}}, a_abs};
          mplier_d = b_abs;
          neg_d    = s.SignedE &
                     (s.SrcAE[WIDTH-1] ^ s.SrcBE[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (s.FlushE) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = DONE;
            res_d   = neg_q ? -acc_d : acc_d;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears the held product.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
    end
  end

  assign s.StallReqE = stall;
  assign s.DoneE     = (state_q == DONE);
  assign s.ResultLoE = res_q[WIDTH-1:0];
  assign s.ResultHiE = res_q[PW-1:WIDTH];
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer.
// Each task drives one scenario and checks it inline.
module tb_mul_sequencer;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one op from IDLE; returns stall count, done cycle, product.
  task automatic run_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sgn,
    input  logic         hold,
    output int           stalls,
    output int           done_at,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
  );
    stalls      = 0;
    done_at     = -1;
    lo          = '0;
    hi          = '0;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    bus.SignedE = sgn;
    bus.FlushE  = 1'b0;
    bus.StartE  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.StallReqE) stalls++;
      if (bus.DoneE && done_at < 0) begin
        done_at = i;
        lo = bus.ResultLoE;
        hi = bus.ResultHiE;
      end
      step();
      if (!hold) bus.StartE = 1'b0;
      if (done_at >= 0) begin
        bus.StartE = 1'b0;
        break;
      end
    end
    bus.StartE = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.StartE  = 1'b1;
    bus.SignedE = 1'b0;
    bus.FlushE  = 1'b0;
    bus.SrcAE   = 32'd3;
    bus.SrcBE   = 32'd4;
    step();
    step();
    bus.StartE = 1'b0;
    @(negedge clk);
    total++;
    if (bus.StallReqE !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%b want=0", bus.StallReqE);
    end
    total++;
    if (bus.DoneE !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b want=0", bus.DoneE);
    end
    total++;
    if (bus.ResultLoE !== 32'h0) begin
      bad++;
      $display("FAIL reset_lo got=%h want=0", bus.ResultLoE);
    end
    total++;
    if (bus.ResultHiE !== 32'h0) begin
      bad++;
      $display("FAIL reset_hi got=%h want=0", bus.ResultHiE);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_unsigned_basic();
    int st, dn;
    logic [W-1:0] lo, hi;
    run_op(32'd7, 32'd6, 1'b0, 1'b1, st, dn, lo, hi);
    total++;
    if (st !== 33) begin
      bad++;
      $display("FAIL u7x6_stall_cycles got=%0d want=33", st);
    end
    total++;
    if (dn !== 33) begin
      bad++;
      $display("FAIL u7x6_done_cycle got=%0d want=33", dn);
    end
    total++;
    if (lo !== 32'd42) begin
      bad++;
      $display("FAIL u7x6_lo got=%h want=2a", lo);
    end
    total++;
    if (hi !== 32'd0) begin
      bad++;
      $display("FAIL u7x6_hi got=%h want=0", hi);
    end
    @(negedge clk);
    total++;
    if (bus.StallReqE !== 1'b0 || bus.DoneE !== 1'b0) begin
      bad++;
      $display("FAIL u7x6_after got=%b%b want=00",
               bus.StallReqE, bus.DoneE);
    end
    step();
  endtask

  task automatic test_signed_products();
    int st, dn;
    logic [W-1:0] lo, hi;
    run_op(-32'sd3, 32'd5, 1'b1, 1'b0, st, dn, lo, hi);
    total++;
    if (lo !== 32'hFFFF_FFF1 || hi !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL s_m3x5 got=%h_%h want=ffffffff_fffffff1", hi, lo);
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
           st, dn, lo, hi);
    total++;
    if (lo !== 32'h0000_0001 || hi !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL u_max got=%h_%h want=fffffffe_00000001", hi, lo);
    end
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0,
           st, dn, lo, hi);
    total++;
    if (lo !== 32'h0000_0001 || hi !== 32'h0000_0000) begin
      bad++;
      $display("FAIL s_m1xm1 got=%h_%h want=00000000_00000001", hi, lo);
    end
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0,
           st, dn, lo, hi);
    total++;
    if (lo !== 32'h0 || hi !== 32'h4000_0000) begin
      bad++;
      $display("FAIL s_minneg got=%h_%h want=40000000_00000000", hi, lo);
    end
    total++;
    if (dn !== 33) begin
      bad++;
      $display("FAIL s_minneg_done got=%0d want=33", dn);
    end
  endtask

  task automatic test_flush_busy();
    int done_seen;
    bus.SrcAE   = 32'd9;
    bus.SrcBE   = 32'd9;
    bus.SignedE = 1'b0;
    bus.StartE  = 1'b1;
    step();
    bus.StartE = 1'b0;
    for (int i = 1; i < 10; i++) step();
    bus.FlushE = 1'b1;
    step();
    bus.FlushE = 1'b0;
    @(negedge clk);
    total++;
    if (bus.StallReqE !== 1'b0) begin
      bad++;
      $display("FAIL flush_stall got=%b want=0", bus.StallReqE);
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.DoneE) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL flush_done got=%0d want=0", done_seen);
    end
    total++;
    if (bus.ResultLoE !== 32'h0 || bus.ResultHiE !== 32'h4000_0000) begin
      bad++;
      $display("FAIL flush_hold got=%h_%h want=40000000_00000000",
               bus.ResultHiE, bus.ResultLoE);
    end
    step();
  endtask

  task automatic test_flush_idle();
    bus.SrcAE  = 32'd2;
    bus.SrcBE  = 32'd2;
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    @(negedge clk);
    total++;
    if (bus.StallReqE !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_stall got=%b want=0", bus.StallReqE);
    end
    step();
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    @(negedge clk);
    total++;
    if (bus.StallReqE !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_next got=%b want=0", bus.StallReqE);
    end
    step();
  endtask

  task automatic test_reset_busy();
    int st, dn;
    logic [W-1:0] lo, hi;
    bus.SrcAE  = 32'd7;
    bus.SrcBE  = 32'd7;
    bus.StartE = 1'b1;
    step();
    bus.StartE = 1'b0;
    for (int i = 1; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.StallReqE !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy_stall got=%b want=0", bus.StallReqE);
    end
    total++;
    if (bus.ResultLoE !== 32'h0 || bus.ResultHiE !== 32'h0) begin
      bad++;
      $display("FAIL rst_busy_res got=%h_%h want=0_0",
               bus.ResultHiE, bus.ResultLoE);
    end
    step();
    run_op(32'd2, 32'd3, 1'b0, 1'b0, st, dn, lo, hi);
    total++;
    if (lo !== 32'd6 || hi !== 32'd0) begin
      bad++;
      $display("FAIL rst_busy_2x3 got=%h_%h want=0_6", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int st, dn;
    logic [W-1:0] lo, hi;
    run_op(32'd100, 32'd200, 1'b0, 1'b0, st, dn, lo, hi);
    total++;
    if (lo !== 32'd20000) begin
      bad++;
      $display("FAIL b2b_first got=%h want=4e20", lo);
    end
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0,
           st, dn, lo, hi);
    total++;
    if (dn !== 33 || st !== 33) begin
      bad++;
      $display("FAIL b2b_timing got=%0d/%0d want=33/33", dn, st);
    end
    total++;
    if (lo !== 32'h0 || hi !== 32'h1) begin
      bad++;
      $display("FAIL b2b_second got=%h_%h want=00000001_00000000", hi, lo);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned_basic();
    test_signed_products();
    test_flush_busy();
    test_flush_idle();
    test_reset_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
